// File: rtl/dm_ctrl.sv
// Load/store controller between the MEM stage and the word-only data memory.
// Latency: loads, SW and errors respond 1 cycle after accept; SH/SB respond after 2 (read-modify-write).
// Backpressure: req_ready drops during the MERGE cycle and while reset is asserted.
module dm_ctrl #(
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_wr,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    // First byte address past the end of the memory.
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);

    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // Read-modify-write buffers captured on the accept cycle of SH/SB.
    logic [31:0] old_q, old_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merge_wd;

    assign req_ready  = rst && (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Alignment and range checks on the incoming request.
    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  misaligned = req_addr[0];
            default:               misaligned = 1'b0;
        endcase
        out_of_range = (req_addr >= ADDR_LIMIT);
        req_err      = misaligned || out_of_range;
    end

    // Little-endian lane selection and extension of the word read from memory.
    always_comb begin
        byte_sel = dm_rd[7:0];
        case (req_addr[1:0])
            2'd0:    byte_sel = dm_rd[7:0];
            2'd1:    byte_sel = dm_rd[15:8];
            2'd2:    byte_sel = dm_rd[23:16];
            default: byte_sel = dm_rd[31:24];
        endcase
        half_sel = req_addr[1] ? dm_rd[31:16] : dm_rd[15:0];
        load_ext = dm_rd;
        case (req_op)
            OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {16'h0000, half_sel};
            OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {24'h000000, byte_sel};
            default: load_ext = dm_rd;
        endcase
    end

    // Old word with only the target lane replaced by the latched store data.
    always_comb begin
        merge_wd = old_q;
        if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0:    merge_wd = {old_q[31:8], wdata_q[7:0]};
                2'd1:    merge_wd = {old_q[31:16], wdata_q[7:0], old_q[7:0]};
                2'd2:    merge_wd = {old_q[31:24], wdata_q[7:0], old_q[15:0]};
                default: merge_wd = {wdata_q[7:0], old_q[23:0]};
            endcase
        end else begin
            merge_wd = addr_q[1] ? {wdata_q, old_q[15:0]} : {old_q[31:16], wdata_q};
        end
    end

    // Next-state, memory port and response logic.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        old_d        = old_q;
        addr_d       = addr_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        dm_addr      = {req_addr[31:2], 2'b00};
        dm_wd        = req_wdata;
        dm_wr        = 1'b0;
        dm_pc        = req_pc;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_op == OP_SW) begin
                        dm_wr        = 1'b1;
                        resp_valid_d = 1'b1;
                    end else if ((req_op == OP_SH) || (req_op == OP_SB)) begin
                        old_d   = dm_rd;
                        addr_d  = req_addr;
                        op_d    = req_op;
                        wdata_d = req_wdata[15:0];
                        pc_d    = req_pc;
                        state_d = MERGE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_ext;
                    end
                end
            end
            MERGE: begin
                dm_addr      = {addr_q[31:2], 2'b00};
                dm_pc        = pc_q;
                dm_wd        = merge_wd;
                // A reset landing on this cycle abandons the write.
                dm_wr        = rst;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, response and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            old_q        <= 32'h0;
            addr_q       <= 32'h0;
            op_q         <= 3'd0;
            wdata_q      <= 16'h0;
            pc_q         <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            old_q        <= old_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: word memory model plus a transaction-level reference of load/store semantics.
// Latency: checks responses 1 cycle (loads, SW, errors) or 2 cycles (SH/SB) after accept.
// Backpressure: checks req_ready low in MERGE and during reset.
module tb_dm_ctrl;

    localparam int DMW = 3072;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_wr;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    int tests;
    int fails;

    logic [31:0] dm_mem  [0:DMW-1];
    logic [31:0] ref_mem [0:DMW-1];
    bit          mem_init;
    bit          oob_wr;

    dm_ctrl #(.DM_WORDS(DMW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_wd      (dm_wd),
        .dm_wr      (dm_wr),
        .dm_pc      (dm_pc),
        .dm_rd      (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Data memory: asynchronous read, write committed on the clock edge.
    assign dm_rd = (dm_addr < 32'(4 * DMW)) ? dm_mem[dm_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DMW; i++) dm_mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (dm_wr) begin
            if (dm_addr < 32'(4 * DMW)) dm_mem[dm_addr[13:2]] <= dm_wd;
            else oob_wr <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: error rule.
    function automatic bit exp_err(input logic [2:0] op, input logic [31:0] addr);
        bit mis;
        mis = 1'b0;
        if (op == 3'd0 || op == 3'd5) mis = (addr % 4) != 0;
        else if (op == 3'd1 || op == 3'd2 || op == 3'd6) mis = (addr % 2) != 0;
        return mis || (addr >= 32'(4 * DMW));
    endfunction

    // Reference: load result from a memory word.
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            3'd0:    return word;
            3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            default: return 32'h0;
        endcase
    endfunction

    // Reference: memory word after a store.
    function automatic logic [31:0] exp_store(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [31:0] old);
        logic [31:0] mask;
        int sh;
        if (op == 3'd5) return wdata;
        if (op == 3'd6) begin
            sh = 16 * ((addr / 2) % 2);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wdata & 32'hFFFF) << sh);
        end
        sh = 8 * (addr % 4);
        mask = 32'hFF << sh;
        return (old & ~mask) | ((wdata & 32'hFF) << sh);
    endfunction

    // One complete request starting in IDLE; checks memory port and response.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc, input string tag);
        bit          err, is_store, rmw;
        logic [31:0] old, nw, exp_rd;
        int          idx;
        err      = exp_err(op, addr);
        is_store = (op >= 3'd5);
        rmw      = !err && (op == 3'd6 || op == 3'd7);
        idx      = (addr < 32'(4 * DMW)) ? int'(addr / 4) : 0;
        old      = (addr < 32'(4 * DMW)) ? ref_mem[idx] : 32'h0;
        nw       = exp_store(op, addr, wdata, old);
        exp_rd   = (err || is_store) ? 32'h0 : exp_load(op, addr, old);

        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
        #1;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        chk({tag, " dm_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
        chk({tag, " acc_wr"}, 32'(dm_wr), 32'(!err && op == 3'd5));
        if (!err && op == 3'd5) begin
            chk({tag, " sw_wd"}, dm_wd, wdata);
            chk({tag, " sw_pc"}, dm_pc, pc);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        #1;
        if (rmw) begin
            chk({tag, " merge_ready"}, 32'(req_ready), 32'd0);
            chk({tag, " merge_wr"}, 32'(dm_wr), 32'd1);
            chk({tag, " merge_wd"}, dm_wd, nw);
            chk({tag, " merge_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
            chk({tag, " merge_pc"}, dm_pc, pc);
            chk({tag, " merge_noresp"}, 32'(resp_valid), 32'd0);
            @(posedge clk); #2;
        end else begin
            chk({tag, " no_merge"}, 32'(req_ready), 32'd1);
            chk({tag, " idle_wr"}, 32'(dm_wr), 32'd0);
        end
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_err"}, 32'(resp_err), 32'(err));
        chk({tag, " resp_rdata"}, resp_rdata, exp_rd);
        if (!err && is_store) ref_mem[idx] = nw;
    endtask

    initial begin
        int errs;
        tests = 0; fails = 0;
        rst = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        for (int i = 0; i < DMW; i++) ref_mem[i] = init_word(i);

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h10;
        #1;
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst dm_wr", 32'(dm_wr), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;

        // Directed: SW/LW, SB read-modify-write.
        do_req(3'd5, 32'h10, 32'hDEADBEEF, 32'h100, "sw10");
        do_req(3'd0, 32'h10, 32'h0, 32'h104, "lw10");
        do_req(3'd7, 32'h12, 32'h55, 32'h108, "sb12");
        chk("sb12 word", ref_mem[4], 32'hDE55BEEF);
        do_req(3'd0, 32'h10, 32'h0, 32'h10C, "lw10b");

        // Load extension.
        do_req(3'd5, 32'h10, 32'h80FF7F01, 32'h110, "sw_ext");
        do_req(3'd3, 32'h10, 32'h0, 32'h114, "lb10");
        do_req(3'd3, 32'h13, 32'h0, 32'h118, "lb13");
        do_req(3'd4, 32'h13, 32'h0, 32'h11C, "lbu13");
        do_req(3'd1, 32'h12, 32'h0, 32'h120, "lh12");
        do_req(3'd2, 32'h12, 32'h0, 32'h124, "lhu12");

        // Errors.
        do_req(3'd0, 32'h11, 32'h0, 32'h128, "lw_mis");
        do_req(3'd6, 32'h13, 32'hAAAA, 32'h12C, "sh_mis");
        do_req(3'd5, 32'h3000, 32'h1234, 32'h130, "sw_oor");
        do_req(3'd0, 32'h2FFC, 32'h0, 32'h134, "lw_last");

        // Reset in the MERGE cycle of an SH.
        req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h14; req_wdata = 32'hBEEF; req_pc = 32'h138;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstmid dm_wr", 32'(dm_wr), 32'd0);
        chk("rstmid ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid ready_after", 32'(req_ready), 32'd1);
        do_req(3'd0, 32'h14, 32'h0, 32'h13C, "rstmid lw");

        // Back-to-back SW then LW.
        req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h20; req_wdata = 32'h12345678; req_pc = 32'h140;
        #1;
        chk("b2b sw_wr", 32'(dm_wr), 32'd1);
        @(posedge clk); #1;
        ref_mem[8] = 32'h12345678;
        req_op = 3'd0; req_wdata = 32'h0; req_pc = 32'h144;
        #1;
        chk("b2b sw_resp", 32'(resp_valid), 32'd1);
        chk("b2b sw_err", 32'(resp_err), 32'd0);
        chk("b2b lw_ready", 32'(req_ready), 32'd1);
        chk("b2b lw_wr", 32'(dm_wr), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk("b2b lw_resp", 32'(resp_valid), 32'd1);
        chk("b2b lw_data", resp_rdata, 32'h12345678);
        @(posedge clk); #2;
        chk("pulse_low", 32'(resp_valid), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            int          sel;
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h2FF0 + 32'($urandom_range(0, 31));
            else if (sel == 1) a = $urandom;
            else               a = 32'($urandom_range(0, 63));
            do_req(op, a, $urandom, $urandom, $sformatf("rnd%0d", n));
        end

        // Final memory image against the reference.
        @(posedge clk); #2;
        errs = 0;
        for (int i = 0; i < DMW; i++) if (dm_mem[i] !== ref_mem[i]) errs++;
        chk("mem_image", 32'(errs), 32'd0);
        chk("oob_write", 32'(oob_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Memory-access controller between the MEM-stage pipeline logic and the word-only data memory `dm`. It accepts one load/store request at a time and checks alignment and range. Sub-word stores (sh/sb) become a two-cycle read-modify-write against `dm`, and sub-word loads are sign- or zero-extended. Every result is returned one cycle after the access completes, with a ready/valid handshake toward the pipeline.

## Interface
Parameters:
- `DM_WORDS`, default 3072: data memory depth in words. Valid byte addresses are 0 … 4·DM_WORDS−1 (0x0000–0x2FFF).

Ports:
- `clk`  in  1  clock. All state changes on the posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept. Equals `rst && state==IDLE`.
- `req_op`  in  3  operation: 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5=SW, 6=SH, 7=SB.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data. Sub-word stores use the low bits.
- `req_pc`  in  32  instruction PC, forwarded to `dm_pc`.
- `resp_valid`  out  1  one-cycle pulse: the request has finished.
- `resp_rdata`  out  32  extended load data. 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range request. Valid with `resp_valid`.
- `dm_addr`  out  32  word address to `dm`, with bits [1:0] forced to 0.
- `dm_wd`  out  32  write data to `dm`.
- `dm_wr`  out  1  write enable to `dm`.
- `dm_pc`  out  32  PC of the write, for `dm`'s write log.
- `dm_rd`  in  32  asynchronous read data from `dm`.

## Operation
- States: IDLE and MERGE.
- A request is accepted when `req_valid && req_ready`.
- Error checks, evaluated on accept:
  - Misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - Out of range: addr ≥ 4·DM_WORDS.
  - Either condition sets the error, which results in: no `dm_wr`, `resp_err`=1, `resp_rdata`=0.
- Lane selection is little-endian:
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Halfword at addr[1]=0 occupies [15:0]; at addr[1]=1 it occupies [31:16].
- Loads (IDLE, on accept):
  - `dm_addr` = {req_addr[31:2],2'b00}.
  - The selected lane of `dm_rd` is extended (LH/LB sign-extend, LHU/LBU zero-extend) and registered into `resp_rdata`.
  - State stays IDLE.
- SW (IDLE, on accept): `dm_wr`=1, `dm_wd`=req_wdata, `dm_pc`=req_pc in the same cycle. State stays IDLE.
- SH/SB, accept cycle:
  - Latch `dm_rd` (the old word), address, op, wdata and pc.
  - `dm_wr`=0. Next state is MERGE.
- SH/SB, MERGE cycle:
  - Drive `dm_wr`=1, `dm_addr` from the latched address, `dm_pc` from the latched pc.
  - `dm_wd` = old word with only the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH).
  - Next state is IDLE.
- `dm_wr` is never asserted while `rst`=0, and never for an errored request.
- An errored SH/SB does not enter MERGE.
- When no request is active, `dm_addr` follows `req_addr` word-aligned and `dm_wr`=0.

## Timing
- Reset values (the cycle after posedge with `rst`=0): state=IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, latched buffers=0. While `rst`=0: `dm_wr`=0 and `req_ready`=0.
- Latency from accept to `resp_valid`:
  - Loads, SW, errors: 1 cycle.
  - SH/SB: 2 cycles. `req_ready`=0 during MERGE.
- Back-to-back requests:
  - Accepts in consecutive cycles are allowed in IDLE.
  - A load accepted in the cycle right after a store's `dm_wr` cycle reads the new data, because `dm` commits on the same edge.
- Reset asserted during MERGE: the write is abandoned (`dm_wr`=0 in that cycle), no `resp_valid` is produced, and the next state is IDLE.
- `resp_valid` is a single-cycle pulse. The pipeline must sample it; the controller does not hold it.

## Test plan
- Reset then SW: SW addr=0x0010, wdata=0xDEADBEEF. Required: `dm_wr`=1 in the accept cycle; `resp_valid`=1, `resp_err`=0 the next cycle. A following LW 0x0010 returns 0xDEADBEEF.
- SB read-modify-write: word 0x0010=0xDEADBEEF, SB addr=0x0012, wdata=0x55. Required: `req_ready`=0 for one cycle; MERGE `dm_wd`=0xDE55BEEF; `resp_valid` 2 cycles after accept.
- Load extension on word 0x0010=0x80FF7F01:
  - LB 0x0010 → 0x00000001
  - LB 0x0013 → 0xFFFFFF80
  - LBU 0x0013 → 0x00000080
  - LH 0x0012 → 0xFFFF80FF
  - LHU 0x0012 → 0x000080FF
- Errors: LW 0x0011 → `resp_err`=1, `resp_rdata`=0. SH 0x0013 → `resp_err`=1, no `dm_wr`, no MERGE. SW 0x3000 → `resp_err`=1, no write.
- Reset mid-RMW: assert `rst`=0 in the MERGE cycle of an SH. Required: `dm_wr`=0, memory unchanged, no `resp_valid`, state IDLE afterwards.
- Back-to-back: SW 0x0020=0x12345678, then LW 0x0020 on the next cycle. Required: the load returns 0x12345678 with 1-cycle latency each.
